// File: rtl/downsampler_pkg.sv
// Shared oversampling constants for the transmit strobe generator and the receive decimator.
// Both ends import these defaults so they agree on samples per symbol.
package downsampler_pkg;

  localparam int NB_COUNT_DEFAULT = 2;
  localparam int NB_DATA_DEFAULT  = 8;
  localparam int N_DEFAULT        = 1 << NB_COUNT_DEFAULT;

  function automatic int oversample_factor(input int nb_count);
    return 1 << nb_count;
  endfunction

endpackage

// File: rtl/downsampler_mod_counter.sv
// Free-running NB_COUNT-bit sample counter that advances on enable and flags its wrap.
// The counter rolls over from its maximum value to 0 without any compare against N.
import downsampler_pkg::*;

module mod_counter #(
  parameter int NB_COUNT = NB_COUNT_DEFAULT
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  output logic [NB_COUNT-1:0] o_count,
  output logic                o_wrap
);

  localparam logic [NB_COUNT-1:0] COUNT_MAX = NB_COUNT'(oversample_factor(NB_COUNT) - 1);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      o_count <= '0;
    end else if (i_enable) begin
      o_count <= o_count + 1'b1;
    end
  end

  assign o_wrap = i_enable && (o_count == COUNT_MAX);

endmodule

// File: rtl/downsampler.sv
// Receive-side decimator: keeps one sample per symbol at the applied phase, strobing o_valid.
// Phase requests are latched only on the counter wrap so a retune never drops or repeats a symbol.
import downsampler_pkg::*;

module downsampler #(
  parameter int NB_COUNT = NB_COUNT_DEFAULT,
  parameter int NB_DATA  = NB_DATA_DEFAULT
) (
  input  logic                      clock,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic signed [NB_DATA-1:0] i_data,
  input  logic [NB_COUNT-1:0]       i_phase,
  output logic                      o_valid,
  output logic signed [NB_DATA-1:0] o_data,
  output logic [NB_COUNT-1:0]       o_phase
);

  logic [NB_COUNT-1:0] count;
  logic                wrap;
  logic [NB_COUNT-1:0] phase_r;
  logic                capture;

  mod_counter #(
    .NB_COUNT (NB_COUNT)
  ) u_count (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_valid),
    .o_count  (count),
    .o_wrap   (wrap)
  );

  assign capture = i_valid && (count == phase_r);

  // Reset wins over a coincident valid sample; the phase request is tracked throughout reset.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      phase_r <= i_phase;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= capture;
      if (capture) begin
        o_data <= i_data;
      end
      if (wrap) begin
        phase_r <= i_phase;
      end
    end
  end

  assign o_phase = phase_r;

endmodule

// File: doc/downsampler.md
# downsampler

Receive-side decimator for the oversampled datapath. The transmit-side control strobes out one symbol every 2^NB_COUNT clocks; this block does the reverse. It accepts the oversampled stream, keeps exactly one sample per symbol period at a programmable phase offset, and presents it with a one-cycle valid strobe to the slicer/BER stage. Phase changes are applied only at symbol boundaries, so a retune never drops or duplicates a symbol.

## Interface

Parameters:
- NB_COUNT, default 2: log2 of the oversampling factor; N = 2^NB_COUNT samples per symbol.
- NB_DATA, default 8: sample width, signed two's complement.

Ports:
- clock, input, 1: single clock; all logic is rising-edge.
- i_reset, input, 1: synchronous, active-high reset.
- i_valid, input, 1: an input sample is present this cycle.
- i_data, input, NB_DATA: input sample, signed.
- i_phase, input, NB_COUNT: requested sampling phase, 0..N-1.
- o_valid, output, 1: one-cycle strobe marking a decimated sample.
- o_data, output, NB_DATA: decimated sample, signed; held between strobes.
- o_phase, output, NB_COUNT: phase currently in effect (the applied phase).

## Operation

- Sample counter `count`:
  - Width NB_COUNT; advances only on accepted samples (i_valid=1).
  - Wraps from N-1 to 0 naturally, with no comparison against N.
- Applied phase register `phase_r`:
  - Loaded from i_phase while i_reset=1.
  - Afterwards, loaded from i_phase only on a cycle where i_valid=1 and count==N-1, i.e. the same edge on which count wraps to 0.
  - A changed i_phase at any other time has no effect until the next wrap.
  - o_phase = phase_r.
- Capture:
  - When i_valid=1 and count==phase_r: o_data <= i_data and o_valid <= 1.
  - On every other cycle: o_valid <= 0 and o_data holds its value.
- Rate guarantee: exactly one o_valid per N accepted samples, for any i_phase sequence.
- Example, N=4, phase_r 0 then 3 with the request made mid-symbol: the block keeps samples 0 and 7.
- No backpressure: the consumer must accept every o_valid.
- Reset values:
  - count=0, o_valid=0, o_data=0.
  - phase_r = i_phase as sampled during reset.
- Reset mid-operation: the partial symbol is discarded. The first sample accepted after reset deasserts is index 0.
- i_reset has priority over i_valid on the same cycle.

## Timing

- Latency: 1 clock from the capture edge (i_valid=1, count==phase_r) to o_valid=1 with o_data equal to that i_data.
- o_valid is high for exactly 1 cycle per capture. Back-to-back strobes occur only when N=1 (NB_COUNT=0 is not supported; the minimum NB_COUNT is 1).
- Gaps in i_valid stretch the symbol period. Counter and phase state are frozen while i_valid=0.
- Phase update: a new i_phase takes effect for the symbol whose first sample follows the wrap edge. o_phase changes on that same edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- Shared package/header holds:
  - Default NB_COUNT and NB_DATA.
  - Derived N = 1 << NB_COUNT.
  - These are shared with the transmit control block, so both ends agree on the oversampling factor.
- Sub-module `mod_counter`: NB_COUNT-bit wrapping counter with clock, i_reset, i_enable, o_count and o_wrap (o_wrap = enable && count==max). The downsampler instantiates it with i_enable=i_valid and uses o_wrap as the phase-load enable.
- The rest stays flat in the top level: the phase register, the capture comparator and the output registers.

## Test plan

- Phase 0, continuous: NB_COUNT=2, i_valid=1 every cycle, i_data ramps 0,1,2,…, i_phase=0 → o_data 0,4,8,12 with o_valid every 4th cycle, each strobe 1 cycle after its sample.
- Phase 2: same ramp with i_phase=2 → o_data 2,6,10; o_phase=2 throughout.
- Mid-symbol retune: i_phase=0 at reset; switch to 3 while count==1 → outputs 0,7,11. o_phase changes 0→3 on the edge that accepts sample 3. Exactly one strobe per symbol.
- Gapped input: i_valid alternating 1,0; i_data ramps only on valid cycles; i_phase=1 → o_data 1,5,9. Strobes are 8 clocks apart and o_data holds between them.
- Reset mid-operation: assert i_reset for 1 cycle after sample 5 is accepted, with i_phase=2 → o_valid=0 and o_data=0 on the next cycle. The first post-reset sample is index 0, and the next capture is the 3rd post-reset sample.
- Reset/valid collision: i_reset=1 and i_valid=1 on the same cycle with count==phase_r → no o_valid strobe follows; count=0.
